mmu_readout: RTL and testbench
==============================

Name: mmu_readout

Overview:
- Reader side of the sample memory (MMU). After capture completes, it issues single-cycle read requests to the MMU's read/q port and collects each 32-bit sample.
- Each sample is split into bytes, LSB first. Disabled channel groups are dropped.
- Bytes go to the UART transmitter over a valid/ready handshake, implementing the SUMP "send captured data" phase.
- Sits between the MMU and the UART TX, and is controlled by the core FSM through start/abort/done.

Parameters:
- MEM_LAT, 1, cycles from mem_read_o high (sampled at clock edge) to mem_q_i valid; legal range 1..4.
- CNT_W, 16, width of the read-count command field.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- start_i  input  1  one-cycle pulse: begin readout; ignored while busy_o=1.
- abort_i  input  1  cancel readout; highest priority after reset.
- read_cnt_i  input  CNT_W  SUMP read count; samples sent = (read_cnt_i+1)*4; latched at start.
- grp_en_i  input  4  byte-group enable, bit k enables byte k (bits 8k+7:8k); latched at start.
- mem_read_o  output  1  read strobe to MMU, one cycle per sample.
- mem_q_i  input  32  sample data from MMU.
- tx_data_o  output  8  byte to UART TX.
- tx_stb_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  UART TX accepts byte this cycle.
- busy_o  output  1  readout in progress.
- done_o  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - all outputs 0; state IDLE; counters and sample register cleared.
  - Applies mid-transfer too: no done_o, tx_stb_o drops the next cycle.
- States: IDLE, REQ, WAIT, SEND, NEXT, DONE.
- IDLE:
  - On start_i=1, latch rem <= {read_cnt_i,2'b11} (18-bit samples-minus-one) and grp_en_i.
  - Go to REQ; busy_o=1 from the next cycle.
- REQ:
  - mem_read_o=1 for exactly one cycle; wait counter loaded with MEM_LAT; go to WAIT.
- WAIT:
  - Count down.
  - The cycle in which mem_q_i is valid (MEM_LAT edges after the REQ edge), capture mem_q_i into smp.
  - Byte index <= lowest enabled index.
  - Go to SEND, or straight to NEXT if the latched mask is 0.
- SEND:
  - tx_stb_o=1, tx_data_o=smp[8*idx +: 8].
  - Data and strobe held stable until a cycle with tx_ready_i=1.
  - On acceptance: idx <= next higher enabled index, staying in SEND; if none remain, go to NEXT.
  - tx_stb_o may stay high across consecutive bytes (back-to-back, one byte per cycle when ready is held high).
- NEXT:
  - If rem==0, go to DONE; else rem <= rem-1 and go to REQ.
  - Minimum 4 cycles per sample when MEM_LAT=1, exclusive of TX stalls.
- DONE:
  - done_o=1 for one cycle, busy_o=0 in the same cycle, then IDLE.
- Boundaries:
  - read_cnt_i=0 gives 4 samples. read_cnt_i=0xFFFF gives 262144 samples; the 18-bit rem counter must not overflow.
  - Mask 0: all samples are still read (mem_read_o pulses) but no tx_stb_o; done_o still pulses.
  - abort_i=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no done_o. Abort during an outstanding read discards the returned data.
  - start_i and abort_i together in IDLE: abort wins, stays IDLE.
  - start_i while busy: ignored, latched values unchanged.
  - tx_ready_i while tx_stb_o=0: no effect.
- Sample order equals MMU read order; the block does no address handling (the MMU owns the read pointer).

Decomposition:
- Shared package (logip_pkg):
  - readout state enum;
  - SMP_W=32, BYTES_PER_SMP=4, REM_W=CNT_W+2;
  - MEM_LAT default constant.
- Natural sub-module: rdo_byte_sel, combinational. Given mask and current index, it returns the next enabled index and a "none left" flag. Used for both first-index and advance.

Test Plan:
- read_cnt=0, mask=4'hF, MMU returns 0x03020100, 0x07060504, ... with tx_ready_i=1 constantly:
  - exactly 4 mem_read_o pulses, 16 bytes 0x00..0x0F in order;
  - done_o one pulse after the last byte.
- read_cnt=0, mask=4'b0101, sample 0xDDCCBBAA: bytes AA, CC per sample only; 8 bytes total.
- Same as the first test but tx_ready_i random ~30% high: tx_data_o stable while tx_stb_o=1 and ready=0; byte stream identical to the first test.
- mask=0, read_cnt=1: 8 mem_read_o pulses, zero tx_stb_o, done_o pulses once.
- abort_i, and separately rst_in=0, asserted while in SEND on the 2nd sample:
  - next cycle busy_o=0, tx_stb_o=0, no done_o;
  - a following start_i runs a full clean readout.
- MEM_LAT=3, read_cnt=0: captured data corresponds to mem_q_i exactly 3 edges after each read pulse; start_i pulsed mid-run is ignored.

Source files
------------

// File: rtl/logip_pkg.sv
// Shared types and constants for the logic analyser readout path.
// Holds the readout state encoding and the sample geometry.
package logip_pkg;

    localparam int SMP_W         = 32;
    localparam int BYTES_PER_SMP = 4;
    localparam int CNT_W_DEF     = 16;
    localparam int REM_W         = CNT_W_DEF + 2;
    localparam int MEM_LAT_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } rdo_state_e;

endpackage

// File: rtl/rdo_byte_sel.sv
// Picks the next enabled byte lane of a sample.
// With first_i set it returns the lowest enabled lane.
module rdo_byte_sel
    import logip_pkg::*;
(
    input  logic [BYTES_PER_SMP-1:0] mask_i,
    input  logic [1:0]               idx_i,
    input  logic                     first_i,
    output logic [1:0]               nxt_o,
    output logic                     none_o
);

    // Scan downwards so the lowest qualifying lane wins.
    always_comb begin
        nxt_o  = '0;
        none_o = 1'b1;
        for (int k = BYTES_PER_SMP - 1; k >= 0; k--) begin
            if (mask_i[k] && (first_i || (k > int'(idx_i)))) begin
                nxt_o  = 2'(k);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmu_readout.sv
// Reads captured samples from the MMU and streams the enabled
// bytes of each sample, LSB first, to the UART transmitter.
module mmu_readout
    import logip_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_in,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [CNT_W-1:0]         read_cnt_i,
    input  logic [BYTES_PER_SMP-1:0] grp_en_i,
    output logic                     mem_read_o,
    input  logic [SMP_W-1:0]         mem_q_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_stb_o,
    input  logic                     tx_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int RW = CNT_W + 2;

    rdo_state_e               state_q, state_d;
    logic [RW-1:0]            rem_q, rem_d;
    logic [BYTES_PER_SMP-1:0] mask_q, mask_d;
    logic [2:0]               wcnt_q, wcnt_d;
    logic [SMP_W-1:0]         smp_q, smp_d;
    logic [1:0]               idx_q, idx_d;

    logic [1:0] sel_nxt;
    logic       sel_none;

    rdo_byte_sel u_sel (
        .mask_i  (mask_q),
        .idx_i   (idx_q),
        .first_i (state_q == ST_WAIT),
        .nxt_o   (sel_nxt),
        .none_o  (sel_none)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mask_q  <= '0;
            wcnt_q  <= '0;
            smp_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            wcnt_q  <= wcnt_d;
            smp_q   <= smp_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        mask_d     = mask_q;
        wcnt_d     = wcnt_q;
        smp_d      = smp_q;
        idx_d      = idx_q;
        mem_read_o = 1'b0;
        tx_stb_o   = 1'b0;
        tx_data_o  = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    rem_d   = {read_cnt_i, 2'b11};
                    mask_d  = grp_en_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                busy_o     = 1'b1;
                mem_read_o = 1'b1;
                wcnt_d     = 3'(MEM_LAT);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                // Last count is the cycle the MMU drives valid data.
                if (wcnt_q == 3'd1) begin
                    smp_d   = mem_q_i;
                    idx_d   = sel_nxt;
                    state_d = sel_none ? ST_NEXT : ST_SEND;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_SEND: begin
                busy_o    = 1'b1;
                tx_stb_o  = 1'b1;
                tx_data_o = smp_q[{idx_q, 3'b000} +: 8];
                if (tx_ready_i) begin
                    if (sel_none) state_d = ST_NEXT;
                    else          idx_d   = sel_nxt;
                end
            end
            ST_NEXT: begin
                busy_o = 1'b1;
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

endmodule

// File: tb/tb_mmu_readout.sv
// Randomised bench for mmu_readout against a byte-stream model.
// Two instances cover MEM_LAT=1 and MEM_LAT=3.
module tb_mmu_readout;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] read_cnt = '0;
    logic [3:0]  grp_en = '0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        abort0 = 1'b0, abort1 = 1'b0;
    logic        rd0, rd1, stb0, stb1, busy0, busy1, done0, done1;
    logic [7:0]  data0, data1;
    logic [31:0] q0, q1;

    mmu_readout #(.MEM_LAT(LAT0), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_in(rst_n), .start_i(start0), .abort_i(abort0),
        .read_cnt_i(read_cnt), .grp_en_i(grp_en), .mem_read_o(rd0),
        .mem_q_i(q0), .tx_data_o(data0), .tx_stb_o(stb0),
        .tx_ready_i(tx_ready), .busy_o(busy0), .done_o(done0)
    );

    mmu_readout #(.MEM_LAT(LAT1), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_in(rst_n), .start_i(start1), .abort_i(abort1),
        .read_cnt_i(read_cnt), .grp_en_i(grp_en), .mem_read_o(rd1),
        .mem_q_i(q1), .tx_data_o(data1), .tx_stb_o(stb1),
        .tx_ready_i(tx_ready), .busy_o(busy1), .done_o(done1)
    );

    int n_assert = 0;
    int n_fail = 0;
    int pct = 100;
    bit sel = 1'b0;

    logic [31:0] img [0:1023];

    // MMU models: data valid only in the cycle LAT edges after the read edge.
    int cd0 = 0, cd1 = 0, nret0 = 0, nret1 = 0;
    always @(posedge clk) begin
        if (rd0) cd0 = LAT0;
        else if (cd0 > 0) cd0--;
        #1;
        if (cd0 == 1) begin q0 = img[nret0 % 1024]; nret0++; end
        else q0 = $urandom;
    end
    always @(posedge clk) begin
        if (rd1) cd1 = LAT1;
        else if (cd1 > 0) cd1--;
        #1;
        if (cd1 == 1) begin q1 = img[nret1 % 1024]; nret1++; end
        else q1 = $urandom;
    end

    always @(posedge clk) begin
        #1;
        tx_ready = ($urandom_range(99) < pct);
    end

    logic       m_rd, m_stb, m_busy, m_done;
    logic [7:0] m_data;
    assign m_rd   = sel ? rd1   : rd0;
    assign m_stb  = sel ? stb1  : stb0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_data = sel ? data1 : data0;

    int cyc = 0, nrd = 0, ndone = 0, acc_cyc = 0, done_cyc = 0;
    int stall_bad = 0, dbusy_bad = 0;
    bit stall_q = 1'b0;
    logic [7:0] hold_q = '0;
    logic [7:0] got [$];

    always @(negedge clk) begin
        cyc++;
        if (m_rd === 1'b1) nrd++;
        if (m_done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
            if (m_busy !== 1'b0) dbusy_bad++;
        end
        if (stall_q && !(m_stb === 1'b1 && m_data === hold_q)) stall_bad++;
        if (m_stb === 1'b1 && tx_ready === 1'b1) begin
            got.push_back(m_data);
            acc_cyc = cyc;
        end
        stall_q = (m_stb === 1'b1) && (tx_ready !== 1'b1);
        hold_q  = m_data;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit st, input bit ab);
        if (s) begin start1 = st; abort1 = ab; end
        else begin start0 = st; abort0 = ab; end
    endtask

    task automatic fill(input bit s, input int n, input int mode);
        int base;
        base = s ? nret1 : nret0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: img[(base + i) % 1024] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
                1: img[(base + i) % 1024] = $urandom;
                default: img[(base + i) % 1024] = 32'hDDCC_BBAA;
            endcase
        end
    endtask

    task automatic run(input bit s, input int cnt, input logic [3:0] m,
                       input int p, input int mode, input bit mid);
        int n, base, b_rd, b_done, b_got, b_stall, b_db, k, lim;
        logic [31:0] w;
        logic [7:0] exp [$];
        n = (cnt + 1) * 4;
        base = s ? nret1 : nret0;
        fill(s, n, mode);
        for (int i = 0; i < n; i++) begin
            w = img[(base + i) % 1024];
            for (int b = 0; b < 4; b++)
                if (m[b]) exp.push_back(w[8*b +: 8]);
        end
        sel = s; pct = p;
        b_rd = nrd; b_done = ndone; b_got = got.size();
        b_stall = stall_bad; b_db = dbusy_bad;
        read_cnt = 16'(cnt); grp_en = m;
        drive(s, 1'b1, 1'b0);
        tick();
        drive(s, 1'b0, 1'b0);
        k = 0;
        lim = n * 80 + 200;
        while (ndone == b_done && k < lim) begin
            tick();
            k++;
            if (mid && k == 12) begin
                read_cnt = 16'h0005; grp_en = 4'h0;
                drive(s, 1'b1, 1'b0);
            end else drive(s, 1'b0, 1'b0);
        end
        repeat (3) tick();
        n_assert++;
        if (k >= lim) begin
            n_fail++;
            $display("FAIL done_timeout: waited %0d cycles, required done within %0d", k, lim);
        end
        n_assert++;
        if (nrd - b_rd !== n) begin
            n_fail++;
            $display("FAIL read_pulses: got %0d, expected %0d", nrd - b_rd, n);
        end
        n_assert++;
        if (ndone - b_done !== 1) begin
            n_fail++;
            $display("FAIL done_pulses: got %0d, expected 1", ndone - b_done);
        end
        n_assert++;
        if (got.size() - b_got !== exp.size()) begin
            n_fail++;
            $display("FAIL byte_count: got %0d, expected %0d", got.size() - b_got, exp.size());
        end
        for (int i = 0; i < exp.size() && b_got + i < got.size(); i++) begin
            n_assert++;
            if (got[b_got + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL byte[%0d]: got %h, expected %h", i, got[b_got + i], exp[i]);
            end
        end
        n_assert++;
        if (stall_bad - b_stall !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles, expected 0", stall_bad - b_stall);
        end
        n_assert++;
        if (dbusy_bad - b_db !== 0) begin
            n_fail++;
            $display("FAIL busy_at_done: %0d, expected 0", dbusy_bad - b_db);
        end
        if (exp.size() > 0) begin
            n_assert++;
            if (!(done_cyc > acc_cyc)) begin
                n_fail++;
                $display("FAIL done_order: done cyc %0d, last byte cyc %0d", done_cyc, acc_cyc);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_assert++;
        if ({rd0, stb0, busy0, done0, data0} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h, expected 000", {rd0, stb0, busy0, done0, data0});
        end
        n_assert++;
        if ({rd1, stb1, busy1, done1, data1} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h, expected 000", {rd1, stb1, busy1, done1, data1});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start_abort();
        int b_rd;
        sel = 1'b0;
        b_rd = nrd;
        drive(1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        n_assert++;
        if (busy0 !== 1'b0 || nrd != b_rd) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy %b reads %0d, expected 0 0", busy0, nrd - b_rd);
        end
    endtask

    task automatic test_cancel(input bit use_rst);
        int b_rd, b_done, k;
        sel = 1'b0; pct = 100;
        fill(1'b0, 4, 0);
        read_cnt = 16'h0; grp_en = 4'hF;
        b_rd = nrd; b_done = ndone;
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        k = 0;
        while (!(nrd - b_rd >= 2 && stb0 === 1'b1) && k < 200) begin
            if (nrd - b_rd >= 2) pct = 0;
            tick();
            k++;
        end
        n_assert++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL cancel_reach_send: timed out after %0d cycles", k);
        end
        if (use_rst) rst_n = 1'b0;
        else drive(1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        n_assert++;
        if ({busy0, stb0, done0} !== 3'b000) begin
            n_fail++;
            $display("FAIL cancel_outputs(rst=%0d): busy/stb/done %b, expected 000", use_rst, {busy0, stb0, done0});
        end
        repeat (10) tick();
        n_assert++;
        if (ndone != b_done) begin
            n_fail++;
            $display("FAIL cancel_no_done(rst=%0d): %0d done pulses, expected 0", use_rst, ndone - b_done);
        end
        run(1'b0, 0, 4'hF, 100, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run(1'(i % 2), $urandom_range(0, 3), 4'($urandom),
                $urandom_range(20, 100), 1, 1'b0);
    endtask

    initial begin
        test_reset();
        run(1'b0, 0, 4'hF, 100, 0, 1'b0);
        run(1'b0, 0, 4'b0101, 100, 2, 1'b0);
        run(1'b0, 0, 4'hF, 30, 0, 1'b0);
        run(1'b0, 1, 4'h0, 100, 1, 1'b0);
        test_start_abort();
        test_cancel(1'b0);
        test_cancel(1'b1);
        run(1'b1, 0, 4'hF, 100, 1, 1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
